// File: rtl/game_hilo_scored_if.sv
// ---------------------------------------------------------------------------
// game_hilo_scored_if
// Groups the player-facing signals of the hi/lo guessing game.
//   btn_higher  : guess "higher" button level (externally synchronised)
//   btn_lower   : guess "lower" button level (externally synchronised)
//   value       : number on the display
//   result      : 00 none, 01 correct, 10 wrong
//   score       : number of correct guesses (SCORE_W bits, saturating)
//   lives_left  : remaining wrong guesses before game over
//   busy        : reveal in progress
//   game_over   : no lives left
// Modports: slave = the game core, master = the player / environment.
// ---------------------------------------------------------------------------
interface game_hilo_scored_if #(
    parameter int SCORE_W = 8
);
    logic               btn_higher;
    logic               btn_lower;
    logic [3:0]         value;
    logic [1:0]         result;
    logic [SCORE_W-1:0] score;
    logic [2:0]         lives_left;
    logic               busy;
    logic               game_over;

    modport slave (
        input  btn_higher, btn_lower,
        output value, result, score, lives_left, busy, game_over
    );

    modport master (
        output btn_higher, btn_lower,
        input  value, result, score, lives_left, busy, game_over
    );
endinterface

// File: rtl/game_hilo_scored.sv
// ---------------------------------------------------------------------------
// game_hilo_scored
// Higher/lower guessing game with score and lives. A free-running 16-bit
// LFSR feeds a draw register holding a number in 0..NUM_MAX. The player
// guesses whether the draw is higher or lower than the displayed number;
// the draw is then revealed for DELAY_TIME cycles and becomes the new
// current number. Running out of lives enters OVER; any guess restarts.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-high reset
//   bus   : game_hilo_scored_if.slave (buttons in, display/status out)
// Compile-time option:
//   TIE_WINS_EN : when defined, draw == current counts as a correct guess
//                 for both buttons; otherwise a tie is wrong for both.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module game_hilo_scored #(
    parameter int          NUM_MAX    = 9,
    parameter int          START_NUM  = 5,
    parameter int          DELAY_TIME = 10_000_000,
    parameter int          LIVES      = 3,
    parameter int          SCORE_W    = 8,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    game_hilo_scored_if.slave bus
);

    typedef enum logic [1:0] {
        ST_CHECK = 2'd0,
        ST_SHOW  = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    localparam int                 CNT_W     = (DELAY_TIME > 1) ? $clog2(DELAY_TIME) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DELAY_TIME - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [3:0]         START_V   = 4'(START_NUM);
    localparam logic [3:0]         MAX_V     = 4'(NUM_MAX);
    localparam logic [2:0]         LIVES_V   = 3'(LIVES);

    // Fibonacci LFSR step, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Judge a guess: 1 = correct. The tie rule is fixed at compile time.
    function automatic logic judge(input logic hi, input logic [3:0] d, input logic [3:0] c);
        logic ok;
`ifdef TIE_WINS_EN
        if (d == c) begin
            ok = 1'b1;
        end else if (hi) begin
            ok = (d > c);
        end else begin
            ok = (d < c);
        end
`else
        if (hi) begin
            ok = (d > c);
        end else begin
            ok = (d < c);
        end
`endif
        return ok;
    endfunction

    state_t             state_r, state_s;
    logic [15:0]        lfsr_r;
    logic [3:0]         draw_r;
    logic [3:0]         cur_r, cur_s;
    logic [3:0]         reveal_r, reveal_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               hi_prev_r, lo_prev_r;
    logic [3:0]         value_r, value_s;
    logic [1:0]         result_r, result_s;
    logic [SCORE_W-1:0] score_r, score_s;
    logic [2:0]         lives_r, lives_s;
    logic               busy_r, busy_s;
    logic               over_r, over_s;
    logic               ev_hi_s, ev_lo_s, ev_s;

    // Rising-edge guess detection; an edge while the other button is down is ignored.
    always_comb begin
        ev_hi_s = bus.btn_higher & ~hi_prev_r & ~bus.btn_lower;
        ev_lo_s = bus.btn_lower  & ~lo_prev_r & ~bus.btn_higher;
        ev_s    = ev_hi_s | ev_lo_s;
    end

    // Next-state and next-output logic for the game FSM.
    always_comb begin
        state_s  = state_r;
        cur_s    = cur_r;
        reveal_s = reveal_r;
        cnt_s    = cnt_r;
        value_s  = value_r;
        result_s = result_r;
        score_s  = score_r;
        lives_s  = lives_r;
        busy_s   = busy_r;
        over_s   = over_r;
        case (state_r)
            ST_CHECK: begin
                if (ev_s) begin
                    // Judged against the draw of the event cycle; revealed from next cycle.
                    reveal_s = draw_r;
                    value_s  = draw_r;
                    busy_s   = 1'b1;
                    cnt_s    = '0;
                    state_s  = ST_SHOW;
                    if (judge(ev_hi_s, draw_r, cur_r)) begin
                        result_s = 2'b01;
                        if (score_r != SCORE_MAX) begin
                            score_s = score_r + SCORE_W'(1);
                        end else begin
                            score_s = score_r;
                        end
                    end else begin
                        result_s = 2'b10;
                        if (lives_r != 3'd0) begin
                            lives_s = lives_r - 3'd1;
                        end else begin
                            lives_s = lives_r;
                        end
                    end
                end else begin
                    state_s = ST_CHECK;
                end
            end
            ST_SHOW: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s  = '0;
                    cur_s  = reveal_r;
                    busy_s = 1'b0;
                    if (lives_r != 3'd0) begin
                        state_s  = ST_CHECK;
                        result_s = 2'b00;
                        over_s   = 1'b0;
                    end else begin
                        state_s  = ST_OVER;
                        result_s = 2'b10;
                        over_s   = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_OVER: begin
                if (ev_s) begin
                    score_s  = '0;
                    lives_s  = LIVES_V;
                    cur_s    = draw_r;
                    value_s  = draw_r;
                    result_s = 2'b00;
                    over_s   = 1'b0;
                    state_s  = ST_CHECK;
                end else begin
                    state_s = ST_OVER;
                end
            end
            default: begin
                state_s  = ST_CHECK;
                busy_s   = 1'b0;
                result_s = 2'b00;
            end
        endcase
    end

    // LFSR, draw register and button history; these run in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r    <= SEED;
            draw_r    <= START_V;
            hi_prev_r <= 1'b1;
            lo_prev_r <= 1'b1;
        end else begin
            lfsr_r    <= lfsr_step(lfsr_r);
            hi_prev_r <= bus.btn_higher;
            lo_prev_r <= bus.btn_lower;
            if (lfsr_r[3:0] <= MAX_V) begin
                draw_r <= lfsr_r[3:0];
            end else begin
                draw_r <= draw_r;
            end
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_CHECK;
            cur_r    <= START_V;
            reveal_r <= START_V;
            cnt_r    <= '0;
            value_r  <= START_V;
            result_r <= 2'b00;
            score_r  <= '0;
            lives_r  <= LIVES_V;
            busy_r   <= 1'b0;
            over_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cur_r    <= cur_s;
            reveal_r <= reveal_s;
            cnt_r    <= cnt_s;
            value_r  <= value_s;
            result_r <= result_s;
            score_r  <= score_s;
            lives_r  <= lives_s;
            busy_r   <= busy_s;
            over_r   <= over_s;
        end
    end

    assign bus.value      = value_r;
    assign bus.result     = result_r;
    assign bus.score      = score_r;
    assign bus.lives_left = lives_r;
    assign bus.busy       = busy_r;
    assign bus.game_over  = over_r;

endmodule

// File: doc/game_hilo_scored.md
GAME_HILO_SCORED -- requirements
Module: game_hilo_scored

Interface
REQ-001 SHALL have parameter NUM_MAX, default 9: largest secret number; legal values 1..15.
REQ-002 SHALL have parameter START_NUM, default 5: first displayed number after reset; must be <= NUM_MAX.
REQ-003 SHALL have parameter DELAY_TIME, default 10_000_000: reveal hold time in clk cycles; must be >= 1.
REQ-004 SHALL have parameter LIVES, default 3: wrong guesses allowed before game over; legal values 1..7.
REQ-005 SHALL have parameter SCORE_W, default 8: score counter width.
REQ-006 SHALL have parameter SEED, default 16'hACE1: LFSR reset value; must be non-zero.
REQ-007 SHALL have one clock and an asynchronous, active-high reset: clk input 1 = clock, all state on rising edge; reset input 1 = asynchronous active-high reset.
REQ-008 SHALL have the remaining ports:
- btn_higher input 1: guess "higher", level; synchronised externally.
- btn_lower input 1: guess "lower", level.
- value output 4: number on display.
- result output 2: 00 none, 01 correct, 10 wrong.
- score output SCORE_W: correct guesses.
- lives_left output 3: remaining lives.
- busy output 1: reveal in progress.
- game_over output 1: no lives left.

Function
REQ-009 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting every cycle regardless of state.
REQ-010 SHALL keep a 4-bit draw register loaded with LFSR[3:0] on each cycle where LFSR[3:0] <= NUM_MAX, else holding; draw is therefore always in 0..NUM_MAX.
REQ-011 SHALL detect guess events on rising edges only: btn registered once; an event occurs when the button is 1 now, was 0 last cycle, and the other button is 0 now.
REQ-012 SHALL ignore simultaneous rising edges of both buttons, and any edge outside state CHECK or OVER.
REQ-013 SHALL implement states CHECK, SHOW, OVER.
REQ-014 CHECK: value = current number, result = 00, busy = 0; a guess event at cycle N SHALL be judged against draw at cycle N.
- At edge N+1: latch draw as reveal number, set result, update score/lives, enter SHOW.
REQ-015 Judgement: higher is correct iff draw > current; lower is correct iff draw < current; draw == current is per REQ-027.
REQ-016 Correct: score +1, saturating at 2^SCORE_W-1. Wrong: lives_left -1.
REQ-017 SHOW: value = reveal number, busy = 1, result held.
- Counter runs 0..DELAY_TIME-1; on the cycle where counter == DELAY_TIME-1 it clears and current <= reveal.
- Next state is CHECK if lives_left > 0, else OVER.
- SHOW therefore lasts exactly DELAY_TIME cycles.
REQ-018 OVER: game_over = 1, busy = 0, value = last reveal, result = 10.
- Any guess event restarts: score 0, lives_left LIVES, current <= draw, result 00, enter CHECK.
REQ-019 Buttons held across a SHOW SHALL NOT produce a new event at SHOW exit; a new rising edge is required.
REQ-020 All outputs SHALL be registered; no combinational path from buttons to outputs.

Reset
REQ-021 SHALL, on reset assertion, immediately and independently of clk: state CHECK, LFSR = SEED, draw = START_NUM, current = START_NUM.
REQ-022 Output reset values: value = START_NUM, result 00, score 0, lives_left LIVES, busy 0, game_over 0.
REQ-023 Button history registers SHALL reset to 1, so a button held through reset is not an event.
REQ-024 Reset mid-SHOW or in OVER SHALL abort without completing the reveal.

Configuration
REQ-025 The TIE_WINS_EN macro SHALL select the tie rule (draw == current) at compile time.
REQ-026 Without TIE_WINS_EN: a tie is wrong for both buttons.
REQ-027 With TIE_WINS_EN: a tie is correct for both buttons. All other behaviour is identical.

Verification
REQ-028 Reset with defaults, hold 5 cycles -> value=5, result=00, score=0, lives_left=3, busy=0, game_over=0.
REQ-029 DELAY_TIME=4; btn_higher edge when draw=7, current=5 -> next cycle result=01, score=1, value=7, busy=1 for exactly 4 cycles; then value=7, result=00.
REQ-030 LIVES=1; btn_lower edge when draw=8, current=5 -> result=10, lives_left=0; after DELAY_TIME cycles game_over=1; a btn_higher edge then gives score=0, lives_left=1, game_over=0.
REQ-031 Both buttons rise on the same cycle, and btn_higher held 20 cycles through SHOW -> no judgement for the simultaneous edge; only one score change.
REQ-032 Tie draw=5, current=5, btn_higher -> result=10 without TIE_WINS_EN; result=01 with it.
REQ-033 SCORE_W=2, four correct guesses -> score sequence 1,2,3,3; reset asserted mid-SHOW -> all outputs at reset values in the same cycle.
